mipi_rx_packet_decoder: RTL and testbench
=========================================

# mipi_rx_packet_decoder

Sits between the lane aligner and the raw depacker on the CSI-2 receive path. Consumes the aligned 4-lane 32-bit byte stream, parses each packet header, and forwards only long-packet payload words to the depacker with a stable packet type. Frame start and frame end short packets are decoded into single-cycle pulses. Malformed or truncated packets are flagged.

## Interface
Parameters:
- VC_FILTER, 2'b00: virtual channel accepted; packets on other VCs are discarded silently.

Ports:
- clk_i  in  1  byte clock, shared with the aligner and the depacker.
- reset_n_i  in  1  asynchronous, active-low reset.
- data_valid_i  in  1  high while the aligner presents a packet; one packet per high window.
- data_i  in  32  lane bytes; [7:0] = lane 0 = earliest byte.
- output_valid_o  out  1  payload word valid; connects to depacker data_valid_i.
- output_o  out  32  payload word, same byte order as data_i.
- packet_type_o  out  3  3 = RAW8 (DT 0x2A), 4 = RAW10 (0x2B), 5 = RAW12 (0x2C); held from header until the next header.
- frame_start_o  out  1  one-cycle pulse on a DT 0x00 short packet.
- frame_end_o  out  1  one-cycle pulse on a DT 0x01 short packet.
- packet_error_o  out  1  one-cycle pulse on truncation or unsupported WC.
- crc_error_o  out  1  one-cycle pulse on a payload CRC mismatch; tied 0 when CRC checking is compiled out.

## Operation
- Header word, the first valid word of a window: DI = [7:0], VC = DI[7:6], DT = DI[5:0], WC = {[23:16],[15:8]}. ECC [31:24] is ignored.
- States: IDLE, PAYLOAD, CRC, WAIT_END.
- IDLE: on data_valid_i=1, decode the header.
  - VC ≠ VC_FILTER → WAIT_END.
  - DT < 0x10 (short packet): pulse frame_start_o or frame_end_o for DT 0x00/0x01, ignore other short DTs, → WAIT_END.
  - DT 0x2A/0x2B/0x2C: latch packet_type_o.
    - WC[1:0] ≠ 0 → pulse packet_error_o, → WAIT_END.
    - WC = 0 → CRC.
    - Otherwise load word counter = WC>>2 (14 bits) → PAYLOAD.
  - Any other DT → WAIT_END.
- PAYLOAD: each valid word is forwarded and the counter decrements; when the counter reaches 1 on a valid word → CRC.
- CRC: the next valid word carries the CRC in [15:0] (LSB byte first); [31:16] are ignored. → WAIT_END.
- WAIT_END: remain until data_valid_i=0, then → IDLE.
- data_valid_i=0 in PAYLOAD or CRC: pulse packet_error_o, no CRC check, → IDLE directly.
- Only PAYLOAD words ever raise output_valid_o. output_o holds its last value when output_valid_o=0.

## Timing
- All outputs are registered. Latency is 1 cycle from a data_i word to the corresponding output_o/output_valid_o.
- Short-packet pulses and packet_type_o update occur 1 cycle after the header word.
- packet_error_o fires 1 cycle after the offending header, or 1 cycle after the falling data_valid_i.
- crc_error_o fires 1 cycle after the CRC word.
- A packet of WC bytes yields exactly WC/4 consecutive output_valid_o cycles. There are no gaps, because the aligner delivers contiguous words.
- A new window may start the cycle after data_valid_i falls; IDLE is reached on that cycle.
- Reset values: state IDLE, counter 0, output_valid_o 0, output_o 0, packet_type_o 0, all pulses 0.
- Reset mid-packet aborts immediately. The next window is treated as a header.

## Configuration
- MIPI_RX_PACKET_DECODER_CRC_EN defined:
  - CRC-16 is computed over payload bytes, 4 bytes per cycle in lane order.
  - Polynomial x^16+x^12+x^5+1, reflected, init 0xFFFF, no final XOR.
  - The CRC register is reset in IDLE.
  - A mismatch against the CRC word pulses crc_error_o; payload is still forwarded.
- Undefined: no CRC logic is instantiated, the CRC word is consumed unchecked, and crc_error_o is constant 0.

## Test plan
- Header 0x04_0008_2B with VC_FILTER=0, then words 0x12345678 and 0x00BCDEF0, then a CRC word → packet_type_o=4; output_valid_o high for 2 cycles carrying those words, each 1 cycle after input; no errors.
- Short header DT 0x00, then separate window DT 0x01 → frame_start_o pulse, then frame_end_o pulse; output_valid_o stays 0.
- Header VC=1 (DI 0x6B), WC=8 → no output_valid_o, no pulses; the following VC0 packet decodes normally.
- Header DT 0x2C, WC=16, data_valid_i dropped after 2 payload words → 2 output words, packet_error_o pulse, state IDLE; next packet decodes correctly.
- Header WC=6 → packet_error_o; DT 0x12 header → silently discarded.
- With MIPI_RX_PACKET_DECODER_CRC_EN, a RAW8 packet with correct CRC → crc_error_o=0. The same packet with one payload bit flipped → crc_error_o pulses 1 cycle after the CRC word.

Source files
------------

// File: rtl/mipi_rx_packet_decoder.sv
// CSI-2 receive packet decoder: parses headers and forwards long-packet payload words.
// It also pulses the frame markers and flags errors. Define MIPI_RX_PACKET_DECODER_CRC_EN to check payload CRC-16.
module mipi_rx_packet_decoder #(
  parameter logic [1:0] VC_FILTER = 2'b00
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        output_valid_o,
  output logic [31:0] output_o,
  output logic [2:0]  packet_type_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        packet_error_o,
  output logic        crc_error_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPayload = 2'd1;
  localparam logic [1:0] StCrc     = 2'd2;
  localparam logic [1:0] StWaitEnd = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic        out_valid_d;
  logic [31:0] out_d;
  logic [2:0]  type_d;
  logic        fs_d, fe_d, perr_d;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;

  assign hdr_vc = data_i[7:6];
  assign hdr_dt = data_i[5:0];
  assign hdr_wc = data_i[23:8];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_d       = output_o;
    type_d      = packet_type_o;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    perr_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_valid_i) begin
          state_d = StWaitEnd;
          if (hdr_vc != VC_FILTER) begin
            state_d = StWaitEnd;
          end else if (hdr_dt < 6'h10) begin
            fs_d = (hdr_dt == 6'h00);
            fe_d = (hdr_dt == 6'h01);
          end else if (hdr_dt >= 6'h2A && hdr_dt <= 6'h2C) begin
            type_d = (hdr_dt == 6'h2A) ? 3'd3 : (hdr_dt == 6'h2B) ? 3'd4 : 3'd5;
            if (hdr_wc[1:0] != 2'b00) begin
              perr_d = 1'b1;
            end else if (hdr_wc == 16'd0) begin
              state_d = StCrc;
            end else begin
              cnt_d   = hdr_wc[15:2];
              state_d = StPayload;
            end
          end
        end
      end
      StPayload: begin
        if (data_valid_i) begin
          out_valid_d = 1'b1;
          out_d       = data_i;
          cnt_d       = cnt_q - 14'd1;
          if (cnt_q == 14'd1) state_d = StCrc;
        end else begin
          perr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StCrc: begin
        if (data_valid_i) begin
          state_d = StWaitEnd;
        end else begin
          perr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitEnd: begin
        if (!data_valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      packet_type_o  <= '0;
      frame_start_o  <= 1'b0;
      frame_end_o    <= 1'b0;
      packet_error_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      output_valid_o <= out_valid_d;
      output_o       <= out_d;
      packet_type_o  <= type_d;
      frame_start_o  <= fs_d;
      frame_end_o    <= fe_d;
      packet_error_o <= perr_d;
    end
  end

`ifdef MIPI_RX_PACKET_DECODER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_err_d;

  // Reflected CCITT, one bit per step, lane 0 byte first and LSB first within each byte.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ word[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  always_comb begin
    crc_d     = crc_q;
    crc_err_d = 1'b0;
    if (state_q == StIdle) begin
      crc_d = 16'hFFFF;
    end else if (state_q == StPayload && data_valid_i) begin
      crc_d = crc16_word(crc_q, data_i);
    end else if (state_q == StCrc && data_valid_i) begin
      crc_err_d = (data_i[15:0] != crc_q);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crc_q       <= 16'hFFFF;
      crc_error_o <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      crc_error_o <= crc_err_d;
    end
  end
`else
  assign crc_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_mipi_rx_packet_decoder.sv
// Bench for mipi_rx_packet_decoder: table vectors, hand sequences and randomized windows
// checked against a packet-level reference model.
module tb_mipi_rx_packet_decoder;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        data_valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        output_valid_o;
  logic [31:0] output_o;
  logic [2:0]  packet_type_o;
  logic        frame_start_o, frame_end_o, packet_error_o, crc_error_o;

  mipi_rx_packet_decoder #(.VC_FILTER(2'b00)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .output_valid_o (output_valid_o),
    .output_o       (output_o),
    .packet_type_o  (packet_type_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .packet_error_o (packet_error_o),
    .crc_error_o    (crc_error_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: record everything the DUT emits, with the cycle it was seen.
  logic [31:0] got_q[$];
  int got_cyc[$], fs_cyc[$], fe_cyc[$], perr_cyc[$], crc_cyc[$];
  logic [31:0] last_out = '0;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      last_out = '0;
    end else begin
      if (output_valid_o) begin
        got_q.push_back(output_o);
        got_cyc.push_back(cyc);
        last_out = output_o;
      end else begin
        check("output_o hold", int'(output_o), int'(last_out));
      end
      if (frame_start_o)  fs_cyc.push_back(cyc);
      if (frame_end_o)    fe_cyc.push_back(cyc);
      if (packet_error_o) perr_cyc.push_back(cyc);
      if (crc_error_o)    crc_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    got_q.delete(); got_cyc.delete(); fs_cyc.delete(); fe_cyc.delete();
    perr_cyc.delete(); crc_cyc.delete();
  endtask

  // Expected outcome of one window.
  logic [31:0] exp_q[$];
  int          exp_fs, exp_fe, exp_perr, exp_perr_off, exp_crc;
  logic [2:0]  exp_type;
  logic [2:0]  model_type;
  int          hcyc;

  function automatic logic [15:0] crc_of(input logic [31:0] q[$]);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(q[i] >> (8 * k));
        c = c ^ {8'h00, b};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
    return c;
  endfunction

  // Reference model: what a whole window should produce, from the packet rules.
  task automatic model(input logic [31:0] w[$]);
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          len, n;
    vc = w[0][7:6];
    dt = w[0][5:0];
    wc = w[0][23:8];
    len = w.size();
    exp_q.delete();
    exp_fs = 0; exp_fe = 0; exp_perr = 0; exp_perr_off = 0; exp_crc = 0;
    exp_type = model_type;
    if (vc != 2'b00) return;
    if (dt < 6'h10) begin
      exp_fs = (dt == 6'h00) ? 1 : 0;
      exp_fe = (dt == 6'h01) ? 1 : 0;
      return;
    end
    if (dt < 6'h2A || dt > 6'h2C) return;
    model_type = 3'(int'(dt) - 'h2A + 3);
    exp_type = model_type;
    if (int'(wc) % 4 != 0) begin
      exp_perr = 1; exp_perr_off = 1;
      return;
    end
    n = int'(wc) / 4;
    for (int i = 1; i <= n && i < len; i++) exp_q.push_back(w[i]);
    if (len < n + 2) begin
      exp_perr = 1; exp_perr_off = len + 1;
      return;
    end
`ifdef MIPI_RX_PACKET_DECODER_CRC_EN
    if (crc_of(exp_q) != w[n+1][15:0]) exp_crc = 1;
`endif
  endtask

  // Drive one window starting at a fresh cycle, then hold data_valid_i low long enough to drain.
  task automatic send(input logic [31:0] w[$]);
    clear_mon();
    @(posedge clk_i); #1;
    hcyc = cyc;
    foreach (w[i]) begin
      if (i > 0) begin @(posedge clk_i); #1; end
      data_valid_i = 1'b1;
      data_i = w[i];
    end
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    data_i = $urandom;
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  task automatic compare(input string tag);
    check({tag, " out_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, " out_word"}, int'(got_q[i]), int'(exp_q[i]));
    if (got_cyc.size() > 0 && exp_q.size() > 0) begin
      check({tag, " out_latency"}, got_cyc[0] - hcyc, 2);
      check({tag, " out_contiguous"}, got_cyc[got_cyc.size()-1] - got_cyc[0], got_cyc.size() - 1);
    end
    check({tag, " packet_type"}, int'(packet_type_o), int'(exp_type));
    check({tag, " frame_start"}, fs_cyc.size(), exp_fs);
    if (fs_cyc.size() > 0) check({tag, " frame_start_cyc"}, fs_cyc[0] - hcyc, 1);
    check({tag, " frame_end"}, fe_cyc.size(), exp_fe);
    if (fe_cyc.size() > 0) check({tag, " frame_end_cyc"}, fe_cyc[0] - hcyc, 1);
    check({tag, " packet_error"}, perr_cyc.size(), exp_perr);
    if (perr_cyc.size() > 0 && exp_perr > 0)
      check({tag, " packet_error_cyc"}, perr_cyc[0] - hcyc, exp_perr_off);
    check({tag, " crc_error"}, crc_cyc.size(), exp_crc);
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          nsent;
    int          nout;
    logic [2:0]  typ;
    int          fs, fe, perr, poff;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] w[$];
  logic [31:0] pq[$];
  logic [5:0]  dt;
  logic [1:0]  vc;
  logic [15:0] wc;
  int          n, sel, h;

  initial begin
    tbl[0]  = '{32'h0400082B, 3, 2, 3'd4, 0, 0, 0, 0};  // RAW10, 2 words
    tbl[1]  = '{32'h00000000, 0, 0, 3'd4, 1, 0, 0, 0};  // frame start
    tbl[2]  = '{32'h00000001, 0, 0, 3'd4, 0, 1, 0, 0};  // frame end
    tbl[3]  = '{32'h0000086B, 3, 0, 3'd4, 0, 0, 0, 0};  // VC1: dropped
    tbl[4]  = '{32'h0000102C, 2, 2, 3'd5, 0, 0, 1, 4};  // truncated RAW12
    tbl[5]  = '{32'h0000062A, 3, 0, 3'd3, 0, 0, 1, 1};  // WC=6
    tbl[6]  = '{32'h00000812, 3, 0, 3'd3, 0, 0, 0, 0};  // unsupported DT
    tbl[7]  = '{32'h0000002A, 1, 0, 3'd3, 0, 0, 0, 0};  // WC=0
    tbl[8]  = '{32'h0000002B, 0, 0, 3'd4, 0, 0, 1, 2};  // WC=0, CRC word missing
    tbl[9]  = '{32'h00000402, 0, 0, 3'd4, 0, 0, 0, 0};  // other short DT
    tbl[10] = '{32'h0000042A, 5, 1, 3'd3, 0, 0, 0, 0};  // trailing words ignored
    tbl[11] = '{32'h000000C0, 0, 0, 3'd3, 0, 0, 0, 0};  // FS on VC3

    model_type = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset output_valid", int'(output_valid_o), 0);
    check("reset output", int'(output_o), 0);
    check("reset packet_type", int'(packet_type_o), 0);
    check("reset pulses", int'({frame_start_o, frame_end_o, packet_error_o, crc_error_o}), 0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;

    // Test-plan packet with fixed data.
    w = '{32'h0400082B, 32'h12345678, 32'h00BCDEF0};
    pq = '{32'h12345678, 32'h00BCDEF0};
    w.push_back({16'h0000, crc_of(pq)});
    exp_q = '{32'h12345678, 32'h00BCDEF0};
    exp_type = 3'd4; exp_fs = 0; exp_fe = 0; exp_perr = 0; exp_perr_off = 0; exp_crc = 0;
    model_type = 3'd4;
    send(w);
    compare("plan_raw10");

    // Table-driven windows.
    for (int t = 0; t < 12; t++) begin
      w.delete(); pq.delete();
      w.push_back(tbl[t].hdr);
      for (int i = 0; i < tbl[t].nsent; i++) w.push_back($urandom);
      for (int i = 1; i <= tbl[t].nout; i++) pq.push_back(w[i]);
      if (tbl[t].nsent > tbl[t].nout) w[tbl[t].nout + 1] = {16'hA5A5, crc_of(pq)};
      exp_q = pq;
      exp_type = tbl[t].typ; exp_fs = tbl[t].fs; exp_fe = tbl[t].fe;
      exp_perr = tbl[t].perr; exp_perr_off = tbl[t].poff; exp_crc = 0;
      model_type = tbl[t].typ;
      send(w);
      compare($sformatf("tbl%0d", t));
    end

    // Back-to-back windows with single idle cycles between them.
    clear_mon();
    @(posedge clk_i); #1; h = cyc;
    data_valid_i = 1'b1; data_i = 32'h00000000;
    @(posedge clk_i); #1; data_valid_i = 1'b0;
    @(posedge clk_i); #1; data_valid_i = 1'b1; data_i = 32'h00000001;
    @(posedge clk_i); #1; data_valid_i = 1'b0;
    @(posedge clk_i); #1; data_valid_i = 1'b1; data_i = 32'h0000042A;
    @(posedge clk_i); #1; data_i = 32'hCAFEF00D;
    pq = '{32'hCAFEF00D};
    @(posedge clk_i); #1; data_i = {16'h0000, crc_of(pq)};
    @(posedge clk_i); #1; data_valid_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    check("b2b fs_count", fs_cyc.size(), 1);
    if (fs_cyc.size() > 0) check("b2b fs_cyc", fs_cyc[0] - h, 1);
    check("b2b fe_count", fe_cyc.size(), 1);
    if (fe_cyc.size() > 0) check("b2b fe_cyc", fe_cyc[0] - h, 3);
    check("b2b out_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("b2b out_word", int'(got_q[0]), int'(32'hCAFEF00D));
      check("b2b out_cyc", got_cyc[0] - h, 6);
    end
    check("b2b perr", perr_cyc.size(), 0);
    check("b2b type", int'(packet_type_o), 3);
    model_type = 3'd3;

    // Good CRC, then the same packet with one payload bit flipped.
    w = '{32'h0000082A, 32'h01020304, 32'hF0E0D0C0};
    pq = '{32'h01020304, 32'hF0E0D0C0};
    w.push_back({16'hFFFF, crc_of(pq)});
    model(w); send(w); compare("crc_good");
    w[2] = w[2] ^ 32'h00000100;
    model(w); send(w); compare("crc_flip");
`ifdef MIPI_RX_PACKET_DECODER_CRC_EN
    check("crc_flip pulse_count", crc_cyc.size(), 1);
    if (crc_cyc.size() > 0) check("crc_flip pulse_cyc", crc_cyc[0] - hcyc, 4);
`endif

    // Reset in the middle of a payload.
    @(posedge clk_i); #1;
    data_valid_i = 1'b1; data_i = 32'h0000102B;
    @(posedge clk_i); #1; data_i = 32'h55AA55AA;
    @(posedge clk_i); #1; reset_n_i = 1'b0; data_valid_i = 1'b0;
    @(negedge clk_i);
    check("midreset output_valid", int'(output_valid_o), 0);
    check("midreset packet_type", int'(packet_type_o), 0);
    check("midreset output", int'(output_o), 0);
    @(posedge clk_i); #1; reset_n_i = 1'b1;
    model_type = '0;
    w = '{32'h0000042C, 32'h89ABCDEF};
    pq = '{32'h89ABCDEF};
    w.push_back({16'h0000, crc_of(pq)});
    model(w); send(w); compare("after_reset");

    // Randomized windows against the reference model.
    for (int r = 0; r < 60; r++) begin
      w.delete(); pq.delete();
      sel = $urandom_range(0, 9);
      case (sel)
        0:       dt = 6'h00;
        1:       dt = 6'h01;
        8:       dt = 6'($urandom_range(2, 15));
        9:       dt = 6'($urandom_range(16, 63));
        default: dt = 6'(6'h2A + 6'($urandom_range(0, 2)));
      endcase
      vc = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wc = 16'($urandom_range(0, 6) * 4);
      if ($urandom_range(0, 7) == 0) wc = wc + 16'($urandom_range(1, 3));
      n = int'(wc) / 4;
      w.push_back({8'($urandom), wc, vc, dt});
      for (int i = 0; i < n; i++) begin
        pq.push_back($urandom);
        w.push_back(pq[i]);
      end
      if ($urandom_range(0, 3) == 0) w.push_back($urandom);
      else w.push_back({16'($urandom), crc_of(pq)});
      for (int i = $urandom_range(0, 2); i > 0; i--) w.push_back($urandom);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, w.size());
        while (w.size() > n) void'(w.pop_back());
      end
      model(w);
      send(w);
      compare($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
